watchdog_controller: RTL and testbench
======================================

// Module: watchdog_controller
// PURPOSE
//  Sequences the windowed watchdog: alternates a closed window (service forbidden) and an open
//  service window (service required), classifies each SERVICE event as good/early/late, counts
//  failures and raises a latched FAULT plus a timed WDRST pulse at threshold.
//  Sits between the host service logic and the system reset generator.
// PARAMETERS
//  CNT_W     16  width of window length inputs and the window down-counter
//  FAIL_W    4   width of failure counter / MAXFAIL
//  RST_PULSE 8   WDRST high duration in CLK cycles on entering FAULT (>=1)
// PORTS
//  CLK      in  1       system clock, rising edge
//  INIT     in  1       asynchronous active-low reset
//  EN       in  1       watchdog enable (level)
//  SERVICE  in  1       service request; rising edge detected internally
//  CWLEN    in  CNT_W   closed window length, cycles (0 treated as 1)
//  SWLEN    in  CNT_W   open service window length, cycles (0 treated as 1)
//  MAXFAIL  in  FAIL_W  failures to FAULT (0 treated as 1)
//  SWSTAT   out 1       1 while in OPEN
//  EARLY    out 1       1-cycle pulse: service in closed window
//  LATE     out 1       1-cycle pulse: open window expired unserviced
//  FAILCNT  out FAIL_W  current failure count, saturating
//  FAULT    out 1       latched fault, cleared only by INIT
//  WDRST    out 1       reset request, RST_PULSE cycles
//  STATE    out 3       IDLE=0 CLOSED=1 OPEN=2 FAULT=3
// BEHAVIOUR
//  - INIT low: STATE=IDLE, counter=0, all outputs 0, edge-detect register 0; async assert, sync release.
//  - svc = SERVICE & ~SERVICE_q (registered previous). All outputs registered; decisions visible 1 cycle after edge.
//  - IDLE: EN=1 -> CLOSED, counter <= max(CWLEN,1)-1. CWLEN/SWLEN/MAXFAIL sampled only at window load.
//  - CLOSED: counter-- each cycle; lasts max(CWLEN,1) cycles; at counter==0 -> OPEN, counter <= max(SWLEN,1)-1.
//    svc in CLOSED (incl. its last cycle): EARLY pulse, FAILCNT+1, reload CLOSED.
//  - OPEN: SWSTAT=1; lasts max(SWLEN,1) cycles. svc (incl. last cycle): good service -> CLOSED reload.
//    counter==0 and no svc: LATE pulse, FAILCNT+1 -> CLOSED reload.
//  - FAILCNT saturates at 2^FAIL_W-1. If post-increment FAILCNT >= max(MAXFAIL,1): -> FAULT instead of CLOSED;
//    EARLY/LATE still pulse that cycle.
//  - FAULT: FAULT=1, WDRST=1 for exactly RST_PULSE cycles starting first FAULT cycle, then 0; SWSTAT=0;
//    EN and SERVICE ignored; exit only via INIT.
//  - EN=0 in CLOSED/OPEN: -> IDLE next cycle, FAILCNT retained, SWSTAT=0; a coincident svc is ignored (EN wins).
//  - INIT mid-window or mid-WDRST: everything returns to reset values immediately.
// CONFIGURATION
//  WDT_FAIL_DECAY_EN defined: each good service decrements FAILCNT by 1 (floor 0).
//  Not defined: FAILCNT only increases; cleared only by INIT.
// STRUCTURE
//  Shared package/include (wdt_defs): state encodings IDLE/CLOSED/OPEN/FAULT, STATE width 3.
//  Sub-module window_timer: loadable CNT_W down-counter (LOAD, LEN, DONE when count==0, zero-as-one rule);
//  controller holds FSM, edge detect, fail counter, WDRST pulse counter.
// TESTING
//  1 CWLEN=4,SWLEN=6,MAXFAIL=3,EN=1, svc 2 cycles into OPEN each period -> SWSTAT high 6-cycle windows
//    starting 4 cycles after CLOSED entry, no EARLY/LATE, FAILCNT=0, 5 periods.
//  2 Same cfg, svc on cycle 2 of CLOSED -> EARLY pulse, FAILCNT=1, CLOSED restarts full 4 cycles.
//  3 Same cfg, no svc -> LATE at end of each OPEN; third LATE -> STATE=FAULT, FAULT=1, WDRST high exactly 8
//    cycles, then SERVICE/EN toggles have no effect until INIT pulse.
//  4 Boundary: svc on last OPEN cycle -> good; svc on last CLOSED cycle -> EARLY; CWLEN=0,SWLEN=0 -> 1-cycle
//    windows; SERVICE held high 20 cycles -> one event only.
//  5 EN dropped mid-OPEN with FAILCNT=2 -> IDLE next cycle, SWSTAT=0, FAILCNT=2; EN re-raised -> CLOSED reload.
//  6 With WDT_FAIL_DECAY_EN: 2 LATE then 1 good service -> FAILCNT=1; without macro -> FAILCNT=2.
//    INIT asserted mid-WDRST -> all outputs 0 in same cycle.

Source files
------------

// File: rtl/watchdog_controller_pkg.sv
// Shared definitions for the windowed watchdog: state encodings and state width.
package watchdog_controller_pkg;

  localparam int unsigned STATE_W = 3;

  typedef logic [STATE_W-1:0] wdt_state_t;

  localparam wdt_state_t StIdle   = 3'd0;
  localparam wdt_state_t StClosed = 3'd1;
  localparam wdt_state_t StOpen   = 3'd2;
  localparam wdt_state_t StFault  = 3'd3;

endpackage

// File: rtl/watchdog_controller_if.sv
// Host-side bundle of the watchdog: enable/service/configuration in, status out.
interface watchdog_controller_if
  import watchdog_controller_pkg::*;
#(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned FAIL_W = 4
) ();

  logic               en;
  logic               service;
  logic [CNT_W-1:0]   cwlen;
  logic [CNT_W-1:0]   swlen;
  logic [FAIL_W-1:0]  maxfail;
  logic               swstat;
  logic               early;
  logic               late;
  logic [FAIL_W-1:0]  failcnt;
  logic               fault;
  logic               wdrst;
  logic [STATE_W-1:0] state;

  modport master (
    output en, service, cwlen, swlen, maxfail,
    input  swstat, early, late, failcnt, fault, wdrst, state
  );

  modport slave (
    input  en, service, cwlen, swlen, maxfail,
    output swstat, early, late, failcnt, fault, wdrst, state
  );

endinterface

// File: rtl/watchdog_controller_window_timer.sv
// Loadable window down-counter; a zero length loads as a one-cycle window.
module watchdog_controller_window_timer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] len,
  input  logic             dec,
  output logic             done
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = (len == '0) ? '0 : len - CNT_W'(1);
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/watchdog_controller.sv
// Windowed watchdog sequencer: closed/open windows, service classification, fail count, fault.
// Optional: define WDT_FAIL_DECAY_EN to let each good service decrement the fail count.
module watchdog_controller
  import watchdog_controller_pkg::*;
#(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned FAIL_W    = 4,
  parameter int unsigned RST_PULSE = 8
) (
  input logic                  clk,
  input logic                  init_n,
  watchdog_controller_if.slave wdt
);

  localparam int unsigned PW = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;

  wdt_state_t        state_q, state_d;
  logic              service_q, svc;
  logic [FAIL_W-1:0] failcnt_q, failcnt_d, fail_inc, maxfail_q, maxfail_d, fail_limit;
  logic              early_q, early_d, late_q, late_d;
  logic              wdrst_q, wdrst_d, swstat_q, fault_q;
  logic [PW-1:0]     pulse_q, pulse_d;
  logic              load, dec, done, over;
  logic [CNT_W-1:0]  load_len;

  assign svc        = wdt.service & ~service_q;
  assign fail_inc   = (failcnt_q == '1) ? failcnt_q : failcnt_q + FAIL_W'(1);
  assign fail_limit = (maxfail_q == '0) ? FAIL_W'(1) : maxfail_q;
  assign over       = (fail_inc >= fail_limit);

  watchdog_controller_window_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk   (clk),
    .rst_n (init_n),
    .load  (load),
    .len   (load_len),
    .dec   (dec),
    .done  (done)
  );

  always_comb begin
    state_d   = state_q;
    failcnt_d = failcnt_q;
    maxfail_d = maxfail_q;
    early_d   = 1'b0;
    late_d    = 1'b0;
    wdrst_d   = wdrst_q;
    pulse_d   = pulse_q;
    load      = 1'b0;
    load_len  = wdt.cwlen;
    dec       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (wdt.en) begin
          state_d = StClosed;
          load    = 1'b1;
        end
      end
      StClosed: begin
        if (!wdt.en) begin
          state_d = StIdle;
        end else if (svc) begin
          early_d   = 1'b1;
          failcnt_d = fail_inc;
          if (over) state_d = StFault;
          else      load    = 1'b1;
        end else if (done) begin
          state_d  = StOpen;
          load     = 1'b1;
          load_len = wdt.swlen;
        end else begin
          dec = 1'b1;
        end
      end
      StOpen: begin
        if (!wdt.en) begin
          state_d = StIdle;
        end else if (svc) begin
          state_d = StClosed;
          load    = 1'b1;
`ifdef WDT_FAIL_DECAY_EN
          if (failcnt_q != '0) failcnt_d = failcnt_q - FAIL_W'(1);
`endif
        end else if (done) begin
          late_d    = 1'b1;
          failcnt_d = fail_inc;
          if (over) begin
            state_d = StFault;
          end else begin
            state_d = StClosed;
            load    = 1'b1;
          end
        end else begin
          dec = 1'b1;
        end
      end
      StFault: begin
        if (pulse_q != '0) pulse_d = pulse_q - PW'(1);
        else               wdrst_d = 1'b0;
      end
      default: state_d = StIdle;
    endcase
    if (load) maxfail_d = wdt.maxfail;
    // WDRST is already high in the first FAULT cycle, so the remaining count is RST_PULSE-1.
    if ((state_d == StFault) && (state_q != StFault)) begin
      wdrst_d = 1'b1;
      pulse_d = PW'(RST_PULSE - 1);
    end
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state_q   <= StIdle;
      service_q <= 1'b0;
      failcnt_q <= '0;
      maxfail_q <= '0;
      early_q   <= 1'b0;
      late_q    <= 1'b0;
      wdrst_q   <= 1'b0;
      pulse_q   <= '0;
      swstat_q  <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      service_q <= wdt.service;
      failcnt_q <= failcnt_d;
      maxfail_q <= maxfail_d;
      early_q   <= early_d;
      late_q    <= late_d;
      wdrst_q   <= wdrst_d;
      pulse_q   <= pulse_d;
      swstat_q  <= (state_d == StOpen);
      fault_q   <= (state_d == StFault);
    end
  end

  assign wdt.state   = state_q;
  assign wdt.swstat  = swstat_q;
  assign wdt.early   = early_q;
  assign wdt.late    = late_q;
  assign wdt.failcnt = failcnt_q;
  assign wdt.fault   = fault_q;
  assign wdt.wdrst   = wdrst_q;

endmodule

// File: tb/tb_watchdog_controller.sv
// Directed bench for watchdog_controller with hand-computed expectations.
module tb_watchdog_controller;

  logic clk = 1'b0;
  logic init_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  watchdog_controller_if #(.CNT_W(16), .FAIL_W(4)) wdt ();

  watchdog_controller #(
    .CNT_W     (16),
    .FAIL_W    (4),
    .RST_PULSE (8)
  ) dut (
    .clk    (clk),
    .init_n (init_n),
    .wdt    (wdt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_state"},   32'(wdt.state),   0);
    chk({tag, "_swstat"},  32'(wdt.swstat),  0);
    chk({tag, "_early"},   32'(wdt.early),   0);
    chk({tag, "_late"},    32'(wdt.late),    0);
    chk({tag, "_failcnt"}, 32'(wdt.failcnt), 0);
    chk({tag, "_fault"},   32'(wdt.fault),   0);
    chk({tag, "_wdrst"},   32'(wdt.wdrst),   0);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reset_dut(input string tag);
    init_n = 1'b0;
    #1;
    chk_zero(tag);
    tick();
    init_n = 1'b1;
  endtask

  task automatic cfg(input int cw, input int sw, input int mf);
    wdt.cwlen   = 16'(cw);
    wdt.swlen   = 16'(sw);
    wdt.maxfail = 4'(mf);
  endtask

  initial begin
    int extra;
    init_n      = 1'b0;
    wdt.en      = 1'b0;
    wdt.service = 1'b0;
    cfg(4, 6, 3);
    tick(2);
    chk_zero("reset");
    init_n = 1'b1;
    tick();
    chk("idle_en0_state", 32'(wdt.state), 0);

    // 1: good service two cycles into each open window
    wdt.en = 1'b1;
    tick();
    chk("t1_entry_state", 32'(wdt.state), 1);
    for (int p = 0; p < 5; p++) begin
      tick(3);
      chk("t1_closed_swstat", 32'(wdt.swstat), 0);
      chk("t1_closed_state", 32'(wdt.state), 1);
      tick();
      chk("t1_open_state", 32'(wdt.state), 2);
      chk("t1_open_swstat", 32'(wdt.swstat), 1);
      tick();
      wdt.service = 1'b1;
      tick();
      chk("t1_reload_state", 32'(wdt.state), 1);
      chk("t1_reload_swstat", 32'(wdt.swstat), 0);
      chk("t1_early", 32'(wdt.early), 0);
      chk("t1_late", 32'(wdt.late), 0);
      chk("t1_failcnt", 32'(wdt.failcnt), 0);
      wdt.service = 1'b0;
    end

    // 2: service on cycle 2 of closed window
    tick();
    wdt.service = 1'b1;
    tick();
    chk("t2_early", 32'(wdt.early), 1);
    chk("t2_failcnt", 32'(wdt.failcnt), 1);
    chk("t2_state", 32'(wdt.state), 1);
    wdt.service = 1'b0;
    tick();
    chk("t2_early_pulse_end", 32'(wdt.early), 0);
    tick(2);
    chk("t2_full_closed", 32'(wdt.state), 1);
    tick();
    chk("t2_open_after4", 32'(wdt.state), 2);

    // 3: no service -> three LATEs -> FAULT with 8-cycle WDRST
    reset_dut("t3_pre_init");
    cfg(4, 6, 3);
    wdt.en = 1'b1;
    tick();
    for (int k = 1; k <= 3; k++) begin
      tick(9);
      chk("t3_last_open_swstat", 32'(wdt.swstat), 1);
      chk("t3_no_late_yet", 32'(wdt.late), 0);
      tick();
      chk("t3_late", 32'(wdt.late), 1);
      chk("t3_failcnt", 32'(wdt.failcnt), 32'(k));
      chk("t3_state", 32'(wdt.state), (k < 3) ? 1 : 3);
      chk("t3_fault", 32'(wdt.fault), (k == 3) ? 1 : 0);
    end
    chk("t3_wdrst_first", 32'(wdt.wdrst), 1);
    for (int i = 2; i <= 8; i++) begin
      wdt.service = ~wdt.service;
      wdt.en      = ~wdt.en;
      tick();
      chk("t3_wdrst_high", 32'(wdt.wdrst), 1);
    end
    tick();
    chk("t3_wdrst_low", 32'(wdt.wdrst), 0);
    for (int i = 0; i < 3; i++) begin
      wdt.service = ~wdt.service;
      wdt.en      = ~wdt.en;
      tick();
    end
    chk("t3_hold_state", 32'(wdt.state), 3);
    chk("t3_hold_fault", 32'(wdt.fault), 1);
    chk("t3_hold_failcnt", 32'(wdt.failcnt), 3);
    chk("t3_hold_swstat", 32'(wdt.swstat), 0);
    chk("t3_hold_wdrst", 32'(wdt.wdrst), 0);
    wdt.service = 1'b0;
    wdt.en      = 1'b1;
    reset_dut("t3_init");

    // 4a: service on last open cycle is good
    cfg(4, 6, 3);
    tick();
    tick(4);
    chk("t4_open", 32'(wdt.state), 2);
    tick(5);
    chk("t4_last_open", 32'(wdt.swstat), 1);
    wdt.service = 1'b1;
    tick();
    chk("t4_lastopen_state", 32'(wdt.state), 1);
    chk("t4_lastopen_late", 32'(wdt.late), 0);
    chk("t4_lastopen_failcnt", 32'(wdt.failcnt), 0);
    wdt.service = 1'b0;
    // 4b: service on last closed cycle is early
    tick(3);
    chk("t4_last_closed", 32'(wdt.state), 1);
    wdt.service = 1'b1;
    tick();
    chk("t4_lastclosed_early", 32'(wdt.early), 1);
    chk("t4_lastclosed_failcnt", 32'(wdt.failcnt), 1);
    chk("t4_lastclosed_state", 32'(wdt.state), 1);
    wdt.service = 1'b0;
    // 4c: zero lengths give one-cycle windows
    cfg(0, 0, 3);
    tick(4);
    chk("t4_zero_open", 32'(wdt.state), 2);
    tick();
    chk("t4_zero_late", 32'(wdt.late), 1);
    chk("t4_zero_failcnt", 32'(wdt.failcnt), 2);
    chk("t4_zero_closed", 32'(wdt.state), 1);
    tick();
    chk("t4_zero_open2", 32'(wdt.state), 2);
    wdt.service = 1'b1;
    tick();
    chk("t4_zero_good", 32'(wdt.state), 1);
    chk("t4_zero_good_failcnt", 32'(wdt.failcnt), 2);
    wdt.service = 1'b0;
    tick();
    chk("t4_zero_open3", 32'(wdt.state), 2);
    // 4d: SERVICE held high is a single event
    reset_dut("t4_pre_hold");
    cfg(4, 6, 3);
    tick();
    wdt.service = 1'b1;
    tick();
    chk("t4_hold_early", 32'(wdt.early), 1);
    extra = 0;
    for (int i = 0; i < 19; i++) begin
      tick();
      if (wdt.early !== 1'b0) extra++;
    end
    chk("t4_hold_single_event", 32'(extra), 0);
    chk("t4_hold_failcnt", 32'(wdt.failcnt), 2);
    chk("t4_hold_state", 32'(wdt.state), 2);

    // 5: EN dropped on the last open cycle wins over expiry
    wdt.en      = 1'b0;
    wdt.service = 1'b0;
    tick();
    chk("t5_idle", 32'(wdt.state), 0);
    chk("t5_swstat", 32'(wdt.swstat), 0);
    chk("t5_failcnt", 32'(wdt.failcnt), 2);
    chk("t5_late", 32'(wdt.late), 0);
    wdt.en = 1'b1;
    tick();
    chk("t5_reload", 32'(wdt.state), 1);
    tick(3);
    chk("t5_closed_len", 32'(wdt.state), 1);
    tick();
    chk("t5_open", 32'(wdt.state), 2);

    // 6: fail decay option, then INIT during WDRST
    reset_dut("t6_pre_init");
    cfg(4, 6, 3);
    tick();
    for (int k = 1; k <= 2; k++) begin
      tick(10);
      chk("t6_late", 32'(wdt.late), 1);
      chk("t6_failcnt", 32'(wdt.failcnt), 32'(k));
    end
    tick(4);
    tick();
    wdt.service = 1'b1;
    wdt.maxfail = 4'd1;
    tick();
    chk("t6_good_state", 32'(wdt.state), 1);
`ifdef WDT_FAIL_DECAY_EN
    chk("t6_decay_failcnt", 32'(wdt.failcnt), 1);
`else
    chk("t6_nodecay_failcnt", 32'(wdt.failcnt), 2);
`endif
    wdt.service = 1'b0;
    tick();
    wdt.service = 1'b1;
    tick();
    chk("t6_fault_early", 32'(wdt.early), 1);
    chk("t6_fault_state", 32'(wdt.state), 3);
    chk("t6_fault_wdrst", 32'(wdt.wdrst), 1);
    wdt.service = 1'b0;
    tick(3);
    chk("t6_mid_wdrst", 32'(wdt.wdrst), 1);
    wdt.en = 1'b0;
    init_n = 1'b0;
    #1;
    chk_zero("t6_init_mid_wdrst");
    tick();
    chk_zero("t6_init_held");
    init_n = 1'b1;
    tick();
    chk("t6_after_init", 32'(wdt.state), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
